seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
//  Accepts a packed hex word plus per-digit decimal points and a blank mask, then scans one digit per refresh slot.
//  The new word is double-buffered so it takes effect only at a frame boundary, which prevents tearing.
//  Sits between datapath/debug registers and the board display pins.
// PARAMETERS
//  DIGITS     8      number of digits scanned (>=1)
//  CLK_DIV    50000  clk cycles per digit slot (>BLANK_CYC)
//  BLANK_CYC  2      cycles at slot start with all anodes off (anti-ghosting, >=0)
// PORTS
//  clk     in   1          system clock, all logic rising-edge
//  rst     in   1          synchronous reset, active-high
//  value   in   4*DIGITS   hex word; digit i = value[4i+3:4i], digit 0 = rightmost
//  dp_in   in   DIGITS     decimal point per digit, 1 = lit
//  blank   in   DIGITS     1 = force digit dark (segments and dp)
//  load    in   1          1-cycle strobe: capture value/dp_in/blank into pending buffer
//  seg     out  7          segments {g,f,e,d,c,b,a}, active-low
//  dp      out  1          decimal point, active-low
//  an      out  DIGITS     anode enables, active-low, at most one low
//  frame   out  1          1-cycle pulse when the display buffer updates
// BEHAVIOUR
//  Single clock clk; reset rst is synchronous and active-high.
//  Reset (next edge with rst=1): seg=7'h7F, dp=1, an=all 1s, frame=0.
//    Also cleared: div_cnt=0, idx=0, display buffer=0, pending buffer=0, pend_flag=0.
//  Counters: div_cnt runs 0..CLK_DIV-1 and wraps.
//    On wrap, idx advances by 1; after DIGITS-1 it wraps to 0.
//  Load: a load pulse writes the pending buffer and sets pend_flag.
//    A load while pend_flag=1 overwrites; the last load wins.
//  Swap: at the edge where idx==DIGITS-1 and div_cnt==CLK_DIV-1 with pend_flag=1:
//    the display buffer takes the pending buffer, pend_flag clears, and frame=1 on the next cycle.
//  Load in the same cycle as a swap: the swap uses the old pending contents.
//    The new load is captured and pend_flag stays 1.
//  Outputs are registered, one cycle latency from (idx, div_cnt, display buffer).
//    an[idx]=0 iff div_cnt>=BLANK_CYC; all other an bits are 1.
//    seg = encode(nibble[idx]); dp = ~dp_buf[idx].
//    If blank_buf[idx]=1: seg=7'h7F and dp=1 (the anode still scans).
//  Encoding, active-low {g..a}:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//  Reset mid-scan: all state returns to reset values and the scan restarts at idx 0.
//    Pending data is discarded.
//  DIGITS=1: idx is held at 1 bit and stays 0; every slot wrap is a frame boundary.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    A digit i>0 is blanked (seg=7'h7F) when it and every digit above it are 0.
//    Digit 0 always shows. dp still follows dp_buf and blank_buf.
//  Not defined: every non-masked digit shows its hex value, including leading zeros.
// TESTING (DIGITS=4, CLK_DIV=4, BLANK_CYC=1 unless noted)
//  Reset: rst high 2 cycles -> seg=7F, dp=1, an=F, frame=0.
//    Then first slot shows an=F for 1 cycle, then an=E, seg=40.
//  Frame swap: load value=16'h12AF, dp_in=4'b0100 mid-frame.
//    Display stays 0000 until idx3 slot ends, then frame pulses once.
//    Next frame shows an=E seg=0E; an=D seg=08; an=B seg=24 dp=0; an=7 seg=79.
//  Back-to-back: loads of 16'h1111 then 16'h2222 before the boundary -> only 2222 is displayed.
//    Load on the exact swap cycle -> applied one frame later.
//  Blank: blank=4'b0010 -> the idx1 slot shows seg=7F, dp=1 while an=D.
//  Macro: value=16'h00A0 with LEADING_ZERO_BLANK_EN -> digits 3,2 show seg=7F, digits 1,0 show 08, 40.
//    Without the macro -> 40,40,08,40.
//  Reset mid-operation: assert rst during idx=2 with pend_flag=1.
//    -> Outputs go to reset values next edge; after release, display 0000 and no frame pulse.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_driver: word, decimal points, blank mask and load strobe in;
// segment, decimal-point, anode and frame pins out.
interface seg_scan_if #(parameter int DIGITS = 8);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic                load;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport master (output value, dp_in, blank, load, input  seg, dp, an, frame);
    modport slave  (input  value, dp_in, blank, load, output seg, dp, an, frame);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).

module seg_scan_lane (
    input  logic [3:0] nib,
    input  logic       dp_en,
    input  logic       blank,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic       dp
);
    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        // Leading-zero suppression darkens segments only; the dp keeps following its own bit.
        if (blank || lz_blank) seg = 7'h7F;
        dp = blank | ~dp_en;
    end
endmodule

module seg_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef struct packed {
        logic [DIGITS-1:0][3:0] nib;
        logic [DIGITS-1:0]      dp;
        logic [DIGITS-1:0]      blank;
    } digit_buf_t;

    logic [CW-1:0]          div_cnt;
    logic [IW-1:0]          idx;
    digit_buf_t             disp_buf, pend_buf;
    logic                   pend_flag;
    logic [6:0]             seg_q;
    logic                   dp_q;
    logic [DIGITS-1:0]      an_q;
    logic                   frame_q;

    logic                   slot_end, swap, lit;
    logic [DIGITS-1:0]      lz_blank;
    logic [DIGITS-1:0][6:0] lane_seg;
    logic [DIGITS-1:0]      lane_dp;
    logic [DIGITS-1:0]      an_nxt;

    assign slot_end = (div_cnt == CNT_LAST);
    // Swap only on the last cycle of the last slot, so a frame never mixes two words.
    assign swap     = slot_end && (idx == IDX_LAST) && pend_flag;

    if (BLANK_CYC == 0) begin : g_noblank
        assign lit = 1'b1;
    end else begin : g_blank
        assign lit = (div_cnt >= CW'(BLANK_CYC));
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_lz
        assign lz_blank[i] = (disp_buf.nib[DIGITS-1:i] == '0);
    end
`else
    assign lz_blank = '0;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        seg_scan_lane u_lane (
            .nib      (disp_buf.nib[i]),
            .dp_en    (disp_buf.dp[i]),
            .blank    (disp_buf.blank[i]),
            .lz_blank (lz_blank[i]),
            .seg      (lane_seg[i]),
            .dp       (lane_dp[i])
        );
    end

    always_comb begin
        an_nxt = '1;
        if (lit) an_nxt[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            idx       <= '0;
            disp_buf  <= '0;
            pend_buf  <= '0;
            pend_flag <= 1'b0;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            an_q      <= '1;
            frame_q   <= 1'b0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (swap) disp_buf <= pend_buf;
            // A load coinciding with a swap lands in the pending buffer for the next frame.
            if (bus.load) pend_buf <= {bus.value, bus.dp_in, bus.blank};
            pend_flag <= bus.load | (pend_flag & ~swap);
            frame_q   <= swap;
            an_q      <= an_nxt;
            seg_q     <= lane_seg[idx];
            dp_q      <= lane_dp[idx];
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule
